// File: rtl/dbg_run_ctrl.sv
// Debug run-control: accepts RUN/HALT/STEP from the host, stalls fetch, waits for
// the pipeline to drain, counts retired instructions and returns one status per command.
module dbg_run_ctrl #(
  parameter int CNT_WD        = 32,
  parameter int DRAIN_TIMEOUT = 64,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic [1:0]        host_req_cmd,
  input  logic [CNT_WD-1:0] host_req_arg,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [1:0]        host_rsp_status,
  output logic [CNT_WD-1:0] host_rsp_retired,
  input  logic              if_fire,
  input  logic              ws_valid,
  input  logic              pipe_empty,
  input  logic              core_stop,
  output logic              fetch_stall,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_HALTED = 2'd1;
  localparam logic [1:0] S_STEP   = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  localparam logic [1:0] CMD_RUN  = 2'd0;
  localparam logic [1:0] CMD_HALT = 2'd1;
  localparam logic [1:0] CMD_STEP = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_ERR     = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_STOPPED = 2'd3;

  localparam int          TW          = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [TW-1:0] DRAIN_MAX  = TW'(DRAIN_TIMEOUT);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [1:0]  RESET_STATE = HALT_ON_RESET ? S_HALTED : S_RUN;

  logic [1:0]        state, state_nxt;
  logic [CNT_WD-1:0] issue_left, issue_left_nxt;
  logic [TW-1:0]     drain_cnt, drain_cnt_nxt;
  logic              stop_flag, stop_flag_nxt;
  logic [CNT_WD-1:0] retired_cnt;
  logic              req_fire;
  logic              launch;
  logic [1:0]        launch_status;
  logic              drain_expired;

  // Handshake: a transfer happens on a cycle where valid && ready are both high at
  // the clock edge. Request valid/cmd/arg must hold until accepted; response
  // valid/status/retired hold until consumed. Ready never depends on the same-side valid.
  assign host_req_ready = !host_rsp_valid && (state == S_RUN || state == S_HALTED);
  assign req_fire       = host_req_valid && host_req_ready;
  assign drain_expired  = (drain_cnt >= DRAIN_LAST);

  assign halted    = (state == S_HALTED);
  assign dbg_state = state;

  always_comb begin
    fetch_stall = 1'b0;
    case (state)
      S_RUN:    fetch_stall = 1'b0;
      S_HALTED: fetch_stall = 1'b1;
      S_STEP:   fetch_stall = (issue_left == '0);
      S_DRAIN:  fetch_stall = 1'b1;
      default:  fetch_stall = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    issue_left_nxt = issue_left;
    drain_cnt_nxt  = drain_cnt;
    stop_flag_nxt  = stop_flag;
    launch         = 1'b0;
    launch_status  = ST_OK;
    case (state)
      S_RUN: begin
        if (req_fire) begin
          case (host_req_cmd)
            CMD_RUN: begin
              launch        = 1'b1;
              launch_status = ST_OK;
            end
            CMD_HALT: begin
              state_nxt     = S_DRAIN;
              drain_cnt_nxt = '0;
            end
            default: begin
              launch        = 1'b1;
              launch_status = ST_ERR;
            end
          endcase
        end
        // A stop merged with an accepted HALT yields a single STOPPED response.
        if (core_stop) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = '0;
          stop_flag_nxt = 1'b1;
        end
      end
      S_HALTED: begin
        if (req_fire) begin
          case (host_req_cmd)
            CMD_RUN: begin
              state_nxt     = S_RUN;
              launch        = 1'b1;
              launch_status = ST_OK;
            end
            CMD_HALT: begin
              launch        = 1'b1;
              launch_status = ST_OK;
            end
            CMD_STEP: begin
              if (host_req_arg == '0) begin
                launch        = 1'b1;
                launch_status = ST_ERR;
              end else begin
                state_nxt      = S_STEP;
                issue_left_nxt = host_req_arg;
              end
            end
            default: begin
              launch        = 1'b1;
              launch_status = ST_ERR;
            end
          endcase
        end
      end
      S_STEP: begin
        if (if_fire && issue_left != '0)
          issue_left_nxt = issue_left - CNT_WD'(1);
        if (core_stop) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = '0;
          stop_flag_nxt = 1'b1;
        end else if (issue_left == '0) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      S_DRAIN: begin
        if (drain_cnt != DRAIN_MAX)
          drain_cnt_nxt = drain_cnt + TW'(1);
        // Completion waits for the previous response to be consumed.
        if (!host_rsp_valid) begin
          if (pipe_empty) begin
            state_nxt     = S_HALTED;
            launch        = 1'b1;
            launch_status = stop_flag ? ST_STOPPED : ST_OK;
            stop_flag_nxt = 1'b0;
          end else if (drain_expired) begin
            state_nxt     = S_HALTED;
            launch        = 1'b1;
            launch_status = ST_TIMEOUT;
            stop_flag_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RESET_STATE;
      issue_left <= '0;
      drain_cnt  <= '0;
      stop_flag  <= 1'b0;
    end else begin
      state      <= state_nxt;
      issue_left <= issue_left_nxt;
      drain_cnt  <= drain_cnt_nxt;
      stop_flag  <= stop_flag_nxt;
    end
  end

  // Retire counter restarts at launch; a commit in the launch cycle opens the new interval.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retired_cnt      <= '0;
      host_rsp_valid   <= 1'b0;
      host_rsp_status  <= ST_OK;
      host_rsp_retired <= '0;
    end else begin
      if (launch) begin
        retired_cnt      <= ws_valid ? CNT_WD'(1) : '0;
        host_rsp_valid   <= 1'b1;
        host_rsp_status  <= launch_status;
        host_rsp_retired <= retired_cnt;
      end else begin
        if (ws_valid && retired_cnt != '1)
          retired_cnt <= retired_cnt + CNT_WD'(1);
        if (host_rsp_valid && host_rsp_ready)
          host_rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Bench for dbg_run_ctrl: directed scenarios then randomized traffic, with a
// reference model feeding an expected-response queue checked by a monitor.
module tb_dbg_run_ctrl;

  localparam int CNT_WD        = 32;
  localparam int DRAIN_TIMEOUT = 64;

  localparam logic [1:0] C_RUN = 2'd0, C_HALT = 2'd1, C_STEP = 2'd2, C_RSV = 2'd3;
  localparam logic [1:0] R_OK = 2'd0, R_ERR = 2'd1, R_TIMEOUT = 2'd2, R_STOPPED = 2'd3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              host_req_valid;
  logic              host_req_ready;
  logic [1:0]        host_req_cmd;
  logic [CNT_WD-1:0] host_req_arg;
  logic              host_rsp_valid;
  logic              host_rsp_ready;
  logic [1:0]        host_rsp_status;
  logic [CNT_WD-1:0] host_rsp_retired;
  logic              if_fire;
  logic              ws_valid;
  logic              pipe_empty;
  logic              core_stop;
  logic              fetch_stall;
  logic              halted;
  logic [1:0]        dbg_state;

  dbg_run_ctrl #(.CNT_WD(CNT_WD), .DRAIN_TIMEOUT(DRAIN_TIMEOUT), .HALT_ON_RESET(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_cmd(host_req_cmd), .host_req_arg(host_req_arg),
    .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .host_rsp_status(host_rsp_status), .host_rsp_retired(host_rsp_retired),
    .if_fire(if_fire), .ws_valid(ws_valid), .pipe_empty(pipe_empty), .core_stop(core_stop),
    .fetch_stall(fetch_stall), .halted(halted), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: what the core is doing, expressed as modes and counters.
  typedef enum int {M_RUN, M_HALTED, M_STEP, M_DRAIN} mode_t;
  mode_t             m_mode;
  logic [CNT_WD-1:0] m_left;
  logic [CNT_WD-1:0] m_ret;
  int                m_age;
  bit                m_stop, m_pend, m_acc;
  bit                fire_want;
  logic [CNT_WD+1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [CNT_WD-1:0] act, logic [CNT_WD-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endfunction

  function automatic void model_reset();
    m_mode = M_RUN; m_left = '0; m_ret = '0; m_age = 0;
    m_stop = 0; m_pend = 0; m_acc = 0;
    exp_q.delete();
  endfunction

  function automatic bit exp_stall();
    return (m_mode == M_DRAIN) || (m_mode == M_HALTED) || (m_mode == M_STEP && m_left == '0);
  endfunction

  // Advance the model over the cycle that just ended, using the inputs held during it.
  function automatic void model_step();
    mode_t      nm = m_mode;
    bit         launch = 0;
    logic [1:0] st = R_OK;
    bit         acc = host_req_valid && !m_pend && (m_mode == M_RUN || m_mode == M_HALTED);
    case (m_mode)
      M_RUN: begin
        if (acc) begin
          if (host_req_cmd == C_RUN) begin launch = 1; st = R_OK; end
          else if (host_req_cmd == C_HALT) nm = M_DRAIN;
          else begin launch = 1; st = R_ERR; end
        end
        if (core_stop) begin nm = M_DRAIN; m_stop = 1; end
        if (nm == M_DRAIN) m_age = 0;
      end
      M_HALTED: begin
        if (acc) begin
          if (host_req_cmd == C_RUN) begin nm = M_RUN; launch = 1; st = R_OK; end
          else if (host_req_cmd == C_HALT) begin launch = 1; st = R_OK; end
          else if (host_req_cmd == C_STEP && host_req_arg != '0) begin nm = M_STEP; m_left = host_req_arg; end
          else begin launch = 1; st = R_ERR; end
        end
      end
      M_STEP: begin
        if (core_stop) begin nm = M_DRAIN; m_stop = 1; m_age = 0; end
        else if (m_left == '0) begin nm = M_DRAIN; m_age = 0; end
        if (if_fire && m_left != '0) m_left--;
      end
      M_DRAIN: begin
        if (!m_pend && pipe_empty) begin
          nm = M_HALTED; launch = 1; st = m_stop ? R_STOPPED : R_OK; m_stop = 0;
        end else if (!m_pend && m_age + 1 >= DRAIN_TIMEOUT) begin
          nm = M_HALTED; launch = 1; st = R_TIMEOUT; m_stop = 0;
        end
        if (m_age < DRAIN_TIMEOUT) m_age++;
      end
      default: nm = M_RUN;
    endcase
    if (m_pend && host_rsp_ready) m_pend = 0;
    if (launch) begin
      exp_q.push_back({st, m_ret});
      m_ret  = ws_valid ? CNT_WD'(1) : '0;
      m_pend = 1;
    end else if (ws_valid && m_ret != '1) begin
      m_ret++;
    end
    m_mode = nm;
    m_acc  = acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    if (m_acc) host_req_valid = 1'b0;
    chk("fetch_stall", CNT_WD'(fetch_stall), CNT_WD'(exp_stall()));
    chk("halted", CNT_WD'(halted), CNT_WD'(m_mode == M_HALTED));
    chk("req_ready", CNT_WD'(host_req_ready), CNT_WD'(!m_pend && (m_mode == M_RUN || m_mode == M_HALTED)));
    chk("rsp_valid", CNT_WD'(host_rsp_valid), CNT_WD'(m_pend));
    if_fire = fire_want && !exp_stall();
  endtask

  task automatic send(input logic [1:0] c, input logic [CNT_WD-1:0] a);
    host_req_cmd   = c;
    host_req_arg   = a;
    host_req_valid = 1'b1;
    for (int i = 0; i < 300 && host_req_valid; i++) tick();
    if (host_req_valid) begin
      fail_now("send_accept");
      host_req_valid = 1'b0;
    end
  endtask

  task automatic settle();
    int i;
    for (i = 0; i < 400; i++) begin
      if ((m_mode == M_RUN || m_mode == M_HALTED) && !m_pend && exp_q.size() == 0 && !host_req_valid)
        break;
      tick();
    end
    if (i == 400) fail_now("settle");
  endtask

  // Monitor: compares every presented response against the head of the expected queue.
  always @(negedge clk) begin
    if (resetn && host_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: got status %0d retired %0d, expected none at %0t",
                 host_rsp_status, host_rsp_retired, $time);
      end else begin
        chk("rsp_status", CNT_WD'(host_rsp_status), CNT_WD'(exp_q[0][CNT_WD+1:CNT_WD]));
        chk("rsp_retired", host_rsp_retired, exp_q[0][CNT_WD-1:0]);
        if (host_rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int pe_pct;
    int r;
    resetn = 1'b0; host_req_valid = 1'b0; host_req_cmd = C_RUN; host_req_arg = '0;
    host_rsp_ready = 1'b1; if_fire = 1'b0; ws_valid = 1'b0; pipe_empty = 1'b0;
    core_stop = 1'b0; fire_want = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", CNT_WD'(host_rsp_valid), '0);
    chk("rst_rsp_status", CNT_WD'(host_rsp_status), '0);
    chk("rst_rsp_retired", host_rsp_retired, '0);
    chk("rst_fetch_stall", CNT_WD'(fetch_stall), '0);
    chk("rst_halted", CNT_WD'(halted), '0);
    chk("rst_req_ready", CNT_WD'(host_req_ready), CNT_WD'(1));
    chk("rst_state", CNT_WD'(dbg_state), '0);
    resetn = 1'b1;

    // Halt with five retirements during the drain.
    repeat (5) tick();
    send(C_HALT, '0);
    ws_valid = 1'b1;
    repeat (5) tick();
    ws_valid = 1'b0;
    repeat (2) tick();
    pipe_empty = 1'b1;
    settle();

    // Single-step three instructions, each retiring in its fetch cycle.
    pipe_empty = 1'b0;
    fire_want  = 1'b1;
    send(C_STEP, CNT_WD'(3));
    for (int i = 0; i < 12; i++) begin
      ws_valid = if_fire;
      tick();
    end
    ws_valid   = 1'b0;
    fire_want  = 1'b0;
    if_fire    = 1'b0;
    pipe_empty = 1'b1;
    settle();

    // Error paths.
    send(C_STEP, '0);    settle();
    send(C_RUN, '0);     settle();
    send(C_STEP, CNT_WD'(5)); settle();
    send(C_RSV, '0);     settle();

    // Drain that never empties.
    pipe_empty = 1'b0;
    send(C_HALT, '0);
    settle();
    send(C_RUN, '0);
    settle();

    // Stop coincident with an accepted HALT, then an unsolicited stop.
    host_req_cmd = C_HALT; host_req_arg = '0; host_req_valid = 1'b1; core_stop = 1'b1;
    tick();
    core_stop = 1'b0;
    repeat (3) tick();
    pipe_empty = 1'b1;
    settle();
    send(C_RUN, '0);
    settle();
    pipe_empty = 1'b0;
    core_stop  = 1'b1;
    tick();
    core_stop = 1'b0;
    repeat (3) tick();
    pipe_empty = 1'b1;
    settle();
    send(C_RUN, '0);
    settle();

    // Back-pressured response, then reset in the middle of a drain.
    host_rsp_ready = 1'b0;
    send(C_RUN, '0);
    repeat (20) tick();
    host_rsp_ready = 1'b1;
    settle();
    pipe_empty = 1'b0;
    send(C_HALT, '0);
    repeat (5) tick();
    resetn = 1'b0;
    #1;
    chk("arst_rsp_valid", CNT_WD'(host_rsp_valid), '0);
    chk("arst_fetch_stall", CNT_WD'(fetch_stall), '0);
    chk("arst_halted", CNT_WD'(halted), '0);
    chk("arst_state", CNT_WD'(dbg_state), '0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Randomized traffic with varying pipeline-empty likelihood.
    for (int blk = 0; blk < 12; blk++) begin
      pe_pct = (blk % 3 == 0) ? 0 : (blk % 3 == 1) ? 15 : 60;
      for (int c = 0; c < 250; c++) begin
        if (!host_req_valid && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 99);
          host_req_cmd   = (r < 25) ? C_RUN : (r < 55) ? C_HALT : (r < 85) ? C_STEP : C_RSV;
          host_req_arg   = CNT_WD'($urandom_range(0, 4));
          host_req_valid = 1'b1;
        end
        fire_want      = 1'($urandom_range(0, 1));
        if_fire        = fire_want && !exp_stall();
        ws_valid       = 1'($urandom_range(0, 1));
        pipe_empty     = ($urandom_range(0, 99) < pe_pct);
        core_stop      = ($urandom_range(0, 99) < 2);
        host_rsp_ready = ($urandom_range(0, 99) < 75);
        tick();
      end
    end
    core_stop = 1'b0; pipe_empty = 1'b1; host_rsp_ready = 1'b1;
    fire_want = 1'b0; ws_valid = 1'b0;
    settle();
    repeat (3) tick();
    chk("exp_q_drained", CNT_WD'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
